// File: rtl/conv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// conv_ctrl_pkg
// Shared definitions for the stride-2 3x3 convolution window controller:
//   - ctrl_state_t : controller FSM states (IDLE, RUN, DONE)
//   - coord_t      : 12-bit pixel / output-map coordinate
//   - out_dim()    : number of stride-2 3x3 windows along an axis of n pixels
// -----------------------------------------------------------------------------
package conv_ctrl_pkg;

    localparam int COORD_W = 12;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    // A 3-wide window stepped by 2 fits (n-3)/2+1 times into n pixels.
    function automatic int out_dim(input int n);
        return (n - 3) / 2 + 1;
    endfunction

endpackage

// File: rtl/conv_window_ctrl_if.sv
// -----------------------------------------------------------------------------
// conv_window_ctrl_if
// Pixel-input and window-output handshake bundle of conv_window_ctrl.
//   pix_valid  : upstream pixel present
//   pix_ready  : controller accepts a pixel this cycle
//   shift_en   : pix_valid & pix_ready, enable for the 3x3 window datapath
//   win_valid  : datapath taps hold a stride-2 window
//   win_ready  : downstream consumes the window
//   out_col    : output-map column of the current window
//   out_row    : output-map row of the current window
// Modports:
//   master : controller side (drives ready/enable/window outputs)
//   slave  : environment side (drives pix_valid and win_ready)
// -----------------------------------------------------------------------------
interface conv_window_ctrl_if;
    import conv_ctrl_pkg::*;

    logic   pix_valid;
    logic   pix_ready;
    logic   shift_en;
    logic   win_valid;
    logic   win_ready;
    coord_t out_col;
    coord_t out_row;

    modport master (
        input  pix_valid,
        input  win_ready,
        output pix_ready,
        output shift_en,
        output win_valid,
        output out_col,
        output out_row
    );

    modport slave (
        output pix_valid,
        output win_ready,
        input  pix_ready,
        input  shift_en,
        input  win_valid,
        input  out_col,
        input  out_row
    );

endinterface

// File: rtl/conv_pos_counter.sv
// -----------------------------------------------------------------------------
// conv_pos_counter
// Raster position of the most recently presented pixel slot. col advances on
// every accepted pixel and wraps from IMG_WIDHT-1 to 0, bumping row; row wraps
// from IMG_HEIGHT-1 to 0 so the counters are naturally back at the origin
// after a complete frame.
// Ports:
//   clk      : clock
//   rst      : asynchronous active-low reset
//   clear    : synchronous return to (0,0), used when a frame is armed
//   advance  : one pixel accepted this cycle
//   col, row : current pixel position
//   last_pix : position is the final pixel of the frame
// -----------------------------------------------------------------------------
module conv_pos_counter
    import conv_ctrl_pkg::*;
#(
    parameter int IMG_WIDHT  = 299,
    parameter int IMG_HEIGHT = 299
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   advance,
    output coord_t col,
    output coord_t row,
    output logic   last_pix
);

    localparam coord_t COL_MAX = coord_t'(IMG_WIDHT - 1);
    localparam coord_t ROW_MAX = coord_t'(IMG_HEIGHT - 1);

    coord_t col_reg;
    coord_t row_reg;
    logic   col_wrap;
    logic   row_wrap;

    assign col_wrap = (col_reg == COL_MAX);
    assign row_wrap = (row_reg == ROW_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (clear) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (advance) begin
            if (col_wrap) begin
                col_reg <= '0;
                row_reg <= row_wrap ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    assign col      = col_reg;
    assign row      = row_reg;
    assign last_pix = col_wrap && row_wrap;

endmodule

// File: rtl/conv_window_ctrl.sv
// -----------------------------------------------------------------------------
// conv_window_ctrl
// Frame controller for a stride-2 3x3 convolution window datapath. After a
// start pulse it accepts IMG_WIDHT x IMG_HEIGHT pixels in raster order, flags
// each position where the datapath taps hold a stride-2 window and reports the
// output-map index of that window, then drains the last window and pulses
// frame_done.
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : asynchronous active-low reset
//   start      : one-cycle pulse, arms a frame (ignored unless idle)
//   bus        : pixel / window handshake (conv_window_ctrl_if.master)
//   frame_done : one-cycle end-of-frame pulse
//   busy       : controller is not idle
//   stall_cnt  : cycles with a window held but not consumed (saturating);
//                present only when CONV_WIN_STALL_CNT_EN is defined
// Optional feature macro: CONV_WIN_STALL_CNT_EN
// -----------------------------------------------------------------------------
module conv_window_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int IMG_WIDHT  = 299,
    parameter int IMG_HEIGHT = 299
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    conv_window_ctrl_if.master        bus,
    output logic                      frame_done,
    output logic                      busy
`ifdef CONV_WIN_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    localparam coord_t WIN_MIN = coord_t'(2);

    ctrl_state_t state_reg;
    ctrl_state_t state_next;

    logic   pix_ready_int;
    logic   shift_en_int;
    logic   frame_done_int;
    logic   counter_clear;
    logic   win_load;

    coord_t col;
    coord_t row;
    logic   last_pix;

    logic   win_valid_reg;
    coord_t out_col_reg;
    coord_t out_row_reg;

    // -------------------------------------------------------------------------
    // Raster position
    // -------------------------------------------------------------------------
    conv_pos_counter #(
        .IMG_WIDHT  (IMG_WIDHT),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clear    (counter_clear),
        .advance  (shift_en_int),
        .col      (col),
        .row      (row),
        .last_pix (last_pix)
    );

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pix_ready_int  = 1'b0;
        frame_done_int = 1'b0;
        counter_clear  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = RUN;
                    counter_clear = 1'b1;
                end
            end
            RUN: begin
                // A held window that is not consumed this cycle blocks the
                // pipe: shifting now would overwrite the datapath taps.
                pix_ready_int = !(win_valid_reg && !bus.win_ready);
                if (bus.pix_valid && pix_ready_int && last_pix) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!win_valid_reg) begin
                    frame_done_int = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign shift_en_int = bus.pix_valid && pix_ready_int;

    // -------------------------------------------------------------------------
    // Window flag and output-map index
    // -------------------------------------------------------------------------
    // The pixel at (col,row) completes a 3x3 neighbourhood whose top-left is
    // (col-2,row-2); the stride-2 grid keeps only even top-left corners, i.e.
    // even col/row, and (col-2)/2 equals col/2-1 for even col.
    assign win_load = shift_en_int && (col >= WIN_MIN) && (row >= WIN_MIN)
                      && !col[0] && !row[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid_reg <= 1'b0;
            out_col_reg   <= '0;
            out_row_reg   <= '0;
        end else if (win_load) begin
            win_valid_reg <= 1'b1;
            out_col_reg   <= (col >> 1) - 1'b1;
            out_row_reg   <= (row >> 1) - 1'b1;
        end else if (bus.win_ready) begin
            win_valid_reg <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Optional stall statistics
    // -------------------------------------------------------------------------
`ifdef CONV_WIN_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
        end else if (counter_clear) begin
            stall_cnt_reg <= '0;
        end else if (win_valid_reg && !bus.win_ready && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.pix_ready = pix_ready_int;
    assign bus.shift_en  = shift_en_int;
    assign bus.win_valid = win_valid_reg;
    assign bus.out_col   = out_col_reg;
    assign bus.out_row   = out_row_reg;
    assign frame_done    = frame_done_int;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_conv_window_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_conv_window_ctrl
// Three controller instances (7x7, 6x5, 9x9) share pix_valid/win_ready; only
// the selected one receives start, and its outputs are routed to o_* signals.
// The expected window sequence of a frame is built from a raster scan of the
// image, keeping every position that completes a stride-2 3x3 window.
// -----------------------------------------------------------------------------
module tb_conv_window_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_drv;
    logic pv;
    logic wr;
    int   sel;

    int checks = 0;
    int errors = 0;

    conv_window_ctrl_if if_a ();
    conv_window_ctrl_if if_b ();
    conv_window_ctrl_if if_c ();

    logic start_a, start_b, start_c;
    logic done_a, done_b, done_c;
    logic busy_a, busy_b, busy_c;
`ifdef CONV_WIN_STALL_CNT_EN
    logic [31:0] stall_a, stall_b, stall_c;
`endif

    assign start_a = start_drv && (sel == 0);
    assign start_b = start_drv && (sel == 1);
    assign start_c = start_drv && (sel == 2);

    assign if_a.pix_valid = pv;
    assign if_a.win_ready = wr;
    assign if_b.pix_valid = pv;
    assign if_b.win_ready = wr;
    assign if_c.pix_valid = pv;
    assign if_c.win_ready = wr;

    conv_window_ctrl #(.IMG_WIDHT(7), .IMG_HEIGHT(7)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .bus        (if_a.master),
        .frame_done (done_a),
        .busy       (busy_a)
`ifdef CONV_WIN_STALL_CNT_EN
        ,
        .stall_cnt  (stall_a)
`endif
    );

    conv_window_ctrl #(.IMG_WIDHT(6), .IMG_HEIGHT(5)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .bus        (if_b.master),
        .frame_done (done_b),
        .busy       (busy_b)
`ifdef CONV_WIN_STALL_CNT_EN
        ,
        .stall_cnt  (stall_b)
`endif
    );

    conv_window_ctrl #(.IMG_WIDHT(9), .IMG_HEIGHT(9)) dut_c (
        .clk        (clk),
        .rst        (rst),
        .start      (start_c),
        .bus        (if_c.master),
        .frame_done (done_c),
        .busy       (busy_c)
`ifdef CONV_WIN_STALL_CNT_EN
        ,
        .stall_cnt  (stall_c)
`endif
    );

    // Outputs of the selected instance
    logic        o_pr, o_se, o_wv, o_fd, o_busy;
    logic [11:0] o_oc, o_or;
    logic [31:0] o_stall;

    always_comb begin
        o_pr    = if_a.pix_ready;
        o_se    = if_a.shift_en;
        o_wv    = if_a.win_valid;
        o_oc    = if_a.out_col;
        o_or    = if_a.out_row;
        o_fd    = done_a;
        o_busy  = busy_a;
        o_stall = '0;
`ifdef CONV_WIN_STALL_CNT_EN
        o_stall = stall_a;
`endif
        if (sel == 1) begin
            o_pr   = if_b.pix_ready;
            o_se   = if_b.shift_en;
            o_wv   = if_b.win_valid;
            o_oc   = if_b.out_col;
            o_or   = if_b.out_row;
            o_fd   = done_b;
            o_busy = busy_b;
`ifdef CONV_WIN_STALL_CNT_EN
            o_stall = stall_b;
`endif
        end else if (sel == 2) begin
            o_pr   = if_c.pix_ready;
            o_se   = if_c.shift_en;
            o_wv   = if_c.win_valid;
            o_oc   = if_c.out_col;
            o_or   = if_c.out_row;
            o_fd   = done_c;
            o_busy = busy_c;
`ifdef CONV_WIN_STALL_CNT_EN
            o_stall = stall_c;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // One complete frame on instance s (w x h) with randomized gaps.
    // stall_n : hold win_ready low for this many cycles at the first window
    // poke    : pulse start again while the frame is running
    // -------------------------------------------------------------------------
    task automatic run_frame(input int s, input int w, input int h,
                             input int pv_pct, input int wr_pct,
                             input int stall_n, input bit poke, input string tag);
        int          exp_c[$];
        int          exp_r[$];
        int          shifts;
        int          wins;
        int          dones;
        int          cyc;
        int          tail;
        int          stall_left;
        bit          stalling;
        bit          prev_hold;
        logic [11:0] prev_c, prev_r;
        logic [11:0] ec, er;
        logic        exp_fd, exp_pr;

        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r >= 2 && c >= 2 && (r % 2) == 0 && (c % 2) == 0) begin
                    exp_c.push_back((c - 2) / 2);
                    exp_r.push_back((r - 2) / 2);
                end
            end
        end

        sel = s;
        @(posedge clk);
        #1;
        pv = 1'b0;
        wr = 1'b1;
        start_drv = 1'b1;
        @(posedge clk);
        #1;
        start_drv = 1'b0;

        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start got %b want 1", tag, o_busy);
        end

        shifts = 0; wins = 0; dones = 0; cyc = 0; tail = 0;
        stall_left = stall_n;
        prev_hold = 1'b0;
        prev_c = '0;
        prev_r = '0;

        while (tail < 3 && cyc < 5000) begin
            pv = ($urandom_range(99) < pv_pct);
            wr = ($urandom_range(99) < wr_pct);
            stalling = 1'b0;
            if (stall_left > 0 && o_wv) begin
                wr = 1'b0;
                stall_left--;
                stalling = 1'b1;
            end
            start_drv = poke && (cyc == 20 || cyc == 21);
            #1;

            checks++;
            if (o_se !== (pv && o_pr)) begin
                errors++;
                $display("FAIL %s shift_en got %b want %b", tag, o_se, pv && o_pr);
            end

            if (shifts < w * h) begin
                exp_pr = !(o_wv && !wr);
                checks++;
                if (o_pr !== exp_pr) begin
                    errors++;
                    $display("FAIL %s pix_ready got %b want %b", tag, o_pr, exp_pr);
                end
            end

            if (prev_hold) begin
                checks++;
                if (o_wv !== 1'b1 || o_oc !== prev_c || o_or !== prev_r) begin
                    errors++;
                    $display("FAIL %s window_hold got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                             tag, o_wv, o_oc, o_or, prev_c, prev_r);
                end
            end

            if (stalling) begin
                checks++;
                if (o_pr !== 1'b0 || o_se !== 1'b0 || o_oc !== 12'd0 || o_or !== 12'd0) begin
                    errors++;
                    $display("FAIL %s stall got pr=%b se=%b (%0d,%0d) want pr=0 se=0 (0,0)",
                             tag, o_pr, o_se, o_oc, o_or);
                end
            end

            exp_fd = (shifts == w * h) && !o_wv && (dones == 0);
            checks++;
            if (o_fd !== exp_fd) begin
                errors++;
                $display("FAIL %s frame_done got %b want %b (shifts %0d)", tag, o_fd, exp_fd, shifts);
            end

            if (dones > 0) begin
                checks++;
                if (o_busy !== 1'b0 || o_pr !== 1'b0 || o_wv !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle_after_done got busy=%b pr=%b wv=%b want 0 0 0",
                             tag, o_busy, o_pr, o_wv);
                end
                tail++;
            end

            if (o_se) shifts++;

            if (o_wv && wr) begin
                wins++;
                checks++;
                if (exp_c.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_window got (%0d,%0d) want none", tag, o_oc, o_or);
                end else begin
                    ec = 12'(exp_c.pop_front());
                    er = 12'(exp_r.pop_front());
                    $display("%s window %0d out (%0d,%0d) exp (%0d,%0d)", tag, wins, o_oc, o_or, ec, er);
                    if (o_oc !== ec || o_or !== er) begin
                        errors++;
                        $display("FAIL %s window_index got (%0d,%0d) want (%0d,%0d)",
                                 tag, o_oc, o_or, ec, er);
                    end
                end
            end

            if (o_fd) dones++;

            prev_hold = o_wv && !wr;
            prev_c = o_oc;
            prev_r = o_or;
            cyc++;
            start_drv = 1'b0;
            @(posedge clk);
            #1;
        end

        pv = 1'b0;
        wr = 1'b1;

        checks++;
        if (cyc >= 5000) begin
            errors++;
            $display("FAIL %s timeout got %0d cycles want frame end", tag, cyc);
        end
        checks++;
        if (shifts != w * h) begin
            errors++;
            $display("FAIL %s pixel_count got %0d want %0d", tag, shifts, w * h);
        end
        checks++;
        if (wins != ((w - 3) / 2 + 1) * ((h - 3) / 2 + 1) || exp_c.size() != 0) begin
            errors++;
            $display("FAIL %s window_count got %0d want %0d", tag, wins,
                     ((w - 3) / 2 + 1) * ((h - 3) / 2 + 1));
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL %s frame_done_count got %0d want 1", tag, dones);
        end
`ifdef CONV_WIN_STALL_CNT_EN
        if (wr_pct == 100) begin
            checks++;
            if (o_stall !== 32'(stall_n)) begin
                errors++;
                $display("FAIL %s stall_cnt got %0d want %0d", tag, o_stall, stall_n);
            end
        end
`endif
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (o_pr !== 1'b0 || o_se !== 1'b0 || o_wv !== 1'b0 || o_oc !== 12'd0 ||
            o_or !== 12'd0 || o_fd !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs got pr=%b se=%b wv=%b (%0d,%0d) fd=%b busy=%b want all 0",
                     tag, o_pr, o_se, o_wv, o_oc, o_or, o_fd, o_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pv = 1'b1;
        wr = 1'b0;
        start_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_zero("reset");
        end
        sel = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        pv = 1'b0;
        wr = 1'b1;
    endtask

    task automatic test_basic_7x7();
        run_frame(0, 7, 7, 100, 100, 0, 1'b0, "basic7x7");
    endtask

    task automatic test_edges_6x5();
        run_frame(1, 6, 5, 100, 100, 0, 1'b0, "edges6x5");
    endtask

    task automatic test_stall();
        run_frame(0, 7, 7, 100, 100, 5, 1'b0, "stall7x7");
    endtask

    task automatic test_reset_midframe();
        int n;
        int cyc;
        sel = 0;
        pv = 1'b0;
        wr = 1'b1;
        @(posedge clk);
        #1;
        start_drv = 1'b1;
        @(posedge clk);
        #1;
        start_drv = 1'b0;
        pv = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 20 && cyc < 200) begin
            #1;
            if (o_se) n++;
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (n != 20) begin
            errors++;
            $display("FAIL midreset pixels got %0d want 20", n);
        end
        rst = 1'b0;
        #1;
        check_zero("midreset_async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (o_se !== 1'b0 || o_busy !== 1'b0 || o_wv !== 1'b0) begin
                errors++;
                $display("FAIL midreset_nostart got se=%b busy=%b wv=%b want 0 0 0",
                         o_se, o_busy, o_wv);
            end
            @(posedge clk);
            #1;
        end
        pv = 1'b0;
        run_frame(0, 7, 7, 100, 100, 0, 1'b0, "after_reset");
    endtask

    task automatic test_start_in_run();
        run_frame(0, 7, 7, 100, 100, 0, 1'b1, "start_in_run");
    endtask

    task automatic test_random_9x9();
        run_frame(2, 9, 9, 70, 60, 0, 1'b0, "random9x9_a");
        run_frame(2, 9, 9, 40, 35, 0, 1'b0, "random9x9_b");
    endtask

    initial begin
        rst = 1'b0;
        start_drv = 1'b0;
        pv = 1'b0;
        wr = 1'b0;
        sel = 0;
        test_reset();
        test_basic_7x7();
        test_edges_6x5();
        test_stall();
        test_reset_midframe();
        test_start_in_run();
        test_random_9x9();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
